// File: rtl/popcount_window_stats.sv
// rtl/popcount_window_stats.sv - windowed sum/min/max/count reduction of a popcount stream
// Optional zero-sample counter: define POPCOUNT_STATS_ZERO_CNT_EN.
module popcount_window_stats #(
    parameter int WIDTH  = 32,
    parameter int WINDOW = 16,
    parameter int CNT_W  = $clog2(WIDTH + 1) + 1,
    parameter int N_W    = $clog2(WINDOW + 1),
    parameter int SUM_W  = CNT_W + N_W
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             data_val_i,
    input  logic [CNT_W-1:0] data_i,
    input  logic             flush_i,
    output logic             stat_val_o,
    input  logic             stat_ready_i,
    output logic [SUM_W-1:0] sum_o,
    output logic [CNT_W-1:0] min_o,
    output logic [CNT_W-1:0] max_o,
    output logic [N_W-1:0]   n_o,
    output logic [N_W-1:0]   zero_cnt_o,
    output logic             overrun_o
);

    typedef enum logic {EMPTY, ACCUM} state_t;

    state_t           state, state_nxt;
    logic [SUM_W-1:0] acc_sum, rec_sum;
    logic [CNT_W-1:0] acc_min, acc_max, rec_min, rec_max, d_c;
    logic [N_W-1:0]   acc_n, rec_n, rec_zc;
    logic             close;

    // rec_* is the window including this cycle's sample, i.e. what a close would emit
    always_comb begin
        d_c       = (data_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : data_i;
        rec_sum   = acc_sum + (data_val_i ? SUM_W'(d_c) : '0);
        rec_n     = acc_n + N_W'(data_val_i);
        rec_min   = acc_min;
        rec_max   = acc_max;
        if (data_val_i) begin
            if (state == EMPTY || d_c < acc_min) rec_min = d_c;
            if (state == EMPTY || d_c > acc_max) rec_max = d_c;
        end
        close     = (state == ACCUM && flush_i) ||
                    (data_val_i && (flush_i || rec_n == N_W'(WINDOW)));
        state_nxt = state;
        if (close)           state_nxt = EMPTY;
        else if (data_val_i) state_nxt = ACCUM;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state <= EMPTY;
        else           state <= state_nxt;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            acc_sum <= '0;
            acc_min <= '0;
            acc_max <= '0;
            acc_n   <= '0;
        end else if (close) begin
            acc_sum <= '0;
            acc_min <= '0;
            acc_max <= '0;
            acc_n   <= '0;
        end else if (data_val_i) begin
            acc_sum <= rec_sum;
            acc_min <= rec_min;
            acc_max <= rec_max;
            acc_n   <= rec_n;
        end
    end

`ifdef POPCOUNT_STATS_ZERO_CNT_EN
    logic [N_W-1:0] acc_zc;
    assign rec_zc = acc_zc + N_W'(data_val_i && d_c == '0);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)       acc_zc <= '0;
        else if (close)      acc_zc <= '0;
        else if (data_val_i) acc_zc <= rec_zc;
    end
`else
    assign rec_zc = '0;
`endif

    // A close may reuse the slot in the very cycle it is being handed off
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            stat_val_o <= 1'b0;
            sum_o      <= '0;
            min_o      <= '0;
            max_o      <= '0;
            n_o        <= '0;
            zero_cnt_o <= '0;
            overrun_o  <= 1'b0;
        end else begin
            overrun_o <= close && stat_val_o && !stat_ready_i;
            if (close && (!stat_val_o || stat_ready_i)) begin
                stat_val_o <= 1'b1;
                sum_o      <= rec_sum;
                min_o      <= rec_min;
                max_o      <= rec_max;
                n_o        <= rec_n;
                zero_cnt_o <= rec_zc;
            end else if (stat_val_o && stat_ready_i) begin
                stat_val_o <= 1'b0;
            end
        end
    end

endmodule
